// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus: request/grant on the address side,
// in-order rvalid/rdata on the response side.
interface fetch_stage_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [31:0]       imem_rdata;

   // Fetch stage side
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   // Instruction memory side
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order requests, buffers
// responses in a small prefetch FIFO and loads the IF/ID register.
// Redirects (trap over branch) flush the FIFO and drop in-flight responses.
// Optional FETCH_PERF_EN adds fetch_cnt / bubble_cnt performance counters.
module fetch_stage #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              dbg,
   input  logic              mem_hold,
   input  logic              hz,
   input  logic              branch,
   input  logic [ADDR_W-1:0] branoff,
   input  logic              trap,
   input  logic [ADDR_W-1:0] trap_vec,
   fetch_stage_if.master     imem,
   output logic [31:0]       ins,
   output logic [ADDR_W-1:0] IF_ID_pres_addr,
   output logic              IF_ID_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       bubble_cnt
`endif
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

   logic [ADDR_W-1:0] pc_reg;
   logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
   logic [CNT_W-1:0]  drop_reg, drop_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W-1:0]  ra_wr_ptr_reg, ra_rd_ptr_reg;
   logic [31:0]       word_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] req_addr_mem [FIFO_DEPTH];

   logic              adv, redir, load, keep, pop, bypass, push, gnt_acc, resp;
   logic [ADDR_W-1:0] target, resp_addr;
   logic [CNT_W:0]    inflight;

   // Stall / redirect decode and the credit-limited request
   always_comb begin
      adv       = !dbg && !mem_hold && !hz;
      redir     = adv && (trap || branch);
      target    = trap ? trap_vec : branoff;
      inflight  = {1'b0, outstanding_reg} + {1'b0, count_reg};
      gnt_acc   = imem.imem_req && imem.imem_gnt;
      resp      = imem.imem_rvalid;
      resp_addr = req_addr_mem[ra_rd_ptr_reg];
      // A response during a redirect cycle is stale by definition.
      keep      = resp && (drop_reg == '0) && !redir;
      load      = adv && !redir;
      pop       = load && (count_reg != '0);
      bypass    = load && (count_reg == '0) && keep;
      push      = keep && !bypass;
      outstanding_next = outstanding_reg + CNT_W'(gnt_acc) - CNT_W'(resp);
      drop_next = drop_reg;
      if (redir)
         drop_next = outstanding_next;
      else if (resp && (drop_reg != '0))
         drop_next = drop_reg - CNT_W'(1);
      count_next = redir ? '0 : count_reg + CNT_W'(push) - CNT_W'(pop);
   end

   // Reset is applied combinationally so no request escapes while Rst is high
   assign imem.imem_req  = !Rst && !dbg && !redir && (inflight < DEPTH_C);
   assign imem.imem_addr = pc_reg;

   // PC, credit counters, FIFO pointers and the IF/ID register
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         pc_reg          <= RESET_PC;
         outstanding_reg <= '0;
         drop_reg        <= '0;
         count_reg       <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         ra_wr_ptr_reg   <= '0;
         ra_rd_ptr_reg   <= '0;
         ins             <= '0;
         IF_ID_pres_addr <= RESET_PC;
         IF_ID_valid     <= 1'b0;
      end else begin
         if (redir)
            pc_reg <= target;
         else if (gnt_acc)
            pc_reg <= pc_reg + ADDR_W'(4);
         outstanding_reg <= outstanding_next;
         drop_reg        <= drop_next;
         count_reg       <= count_next;
         if (gnt_acc) ra_wr_ptr_reg <= ra_wr_ptr_reg + PTR_W'(1);
         if (resp)    ra_rd_ptr_reg <= ra_rd_ptr_reg + PTR_W'(1);
         if (redir) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            ins         <= '0;
            IF_ID_valid <= 1'b0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (pop) begin
               ins             <= word_mem[rd_ptr_reg];
               IF_ID_pres_addr <= addr_mem[rd_ptr_reg];
               IF_ID_valid     <= 1'b1;
            end else if (bypass) begin
               ins             <= imem.imem_rdata;
               IF_ID_pres_addr <= resp_addr;
               IF_ID_valid     <= 1'b1;
            end else if (load) begin
               ins         <= '0;
               IF_ID_valid <= 1'b0;
            end
         end
      end
   end

   // Storage for prefetched {addr, word} entries and granted request addresses
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            word_mem[i]     <= '0;
            addr_mem[i]     <= '0;
            req_addr_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            word_mem[wr_ptr_reg] <= imem.imem_rdata;
            addr_mem[wr_ptr_reg] <= resp_addr;
         end
         if (gnt_acc)
            req_addr_mem[ra_wr_ptr_reg] <= pc_reg;
      end
   end

`ifdef FETCH_PERF_EN
   // Count real IF/ID loads and bubble loads on every advancing cycle
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         fetch_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (adv) begin
         if (pop || bypass)
            fetch_cnt <= fetch_cnt + 32'd1;
         else
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

   // A response with nothing outstanding is a memory protocol violation
   assert property (@(posedge clk) disable iff (Rst)
      imem.imem_rvalid |-> (outstanding_reg != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a 1- or 2-cycle instruction memory
// model returning rdata = addr | 0x13.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        Rst = 1'b1;
   logic        dbg = 1'b0, mem_hold = 1'b0, hz = 1'b0;
   logic        branch = 1'b0, trap = 1'b0;
   logic [31:0] branoff = '0, trap_vec = '0;
   logic [31:0] ins, pres;
   logic        valid;
   logic        gnt_en = 1'b1;
   logic        lat2 = 1'b0;
   int          checks = 0;
   int          errors = 0;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt, bubble_cnt;
`endif

   fetch_stage_if #(.ADDR_W(32)) mif ();

   fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk             (clk),
      .Rst             (Rst),
      .dbg             (dbg),
      .mem_hold        (mem_hold),
      .hz              (hz),
      .branch          (branch),
      .branoff         (branoff),
      .trap            (trap),
      .trap_vec        (trap_vec),
      .imem            (mif.master),
      .ins             (ins),
      .IF_ID_pres_addr (pres),
      .IF_ID_valid     (valid)
`ifdef FETCH_PERF_EN
      ,
      .fetch_cnt       (fetch_cnt),
      .bubble_cnt      (bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: response 1 or 2 cycles after grant, in order
   logic        s1_v, s2_v;
   logic [31:0] s1_a, s2_a;
   always @(posedge clk or posedge Rst) begin
      if (Rst) begin
         s1_v <= 1'b0; s2_v <= 1'b0; s1_a <= '0; s2_a <= '0;
      end else begin
         s1_v <= mif.imem_req && mif.imem_gnt;
         s1_a <= mif.imem_addr;
         s2_v <= s1_v;
         s2_a <= s1_a;
      end
   end
   assign mif.imem_gnt    = gnt_en;
   assign mif.imem_rvalid = lat2 ? s2_v : s1_v;
   assign mif.imem_rdata  = (lat2 ? s2_a : s1_a) | 32'h13;

   task automatic step();
      @(posedge clk); #1;
      $display("t=%0t ins=%h pres=%h v=%b req=%b addr=%h", $time, ins, pres, valid,
               mif.imem_req, mif.imem_addr);
   endtask

   task automatic do_reset(input logic use_lat2, input logic gnt_val);
      @(negedge clk);
      Rst = 1'b1; lat2 = use_lat2; gnt_en = gnt_val;
      dbg = 0; mem_hold = 0; hz = 0; branch = 0; trap = 0;
      @(posedge clk); @(negedge clk);
      Rst = 1'b0;
      @(posedge clk); #1;   // first edge after release: one bubble, request 0 granted
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b1);
      step(); step();
      checks++; if (ins !== 32'h17) begin errors++; $display("FAIL reset_pre_ins got %h exp %h", ins, 32'h17); end
      #3 Rst = 1'b1; #1;
      checks++; if (ins !== 32'h0) begin errors++; $display("FAIL reset_ins got %h exp 0", ins); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      checks++; if (mif.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mif.imem_req); end
      checks++; if (pres !== 32'h0) begin errors++; $display("FAIL reset_pres got %h exp 0", pres); end
   endtask

   task automatic test_stream();
      do_reset(1'b0, 1'b1);
      checks++; if (ins !== 32'h0 || mif.imem_addr !== 32'h4) begin errors++; $display("FAIL stream_e1 ins %h addr %h exp 0/4", ins, mif.imem_addr); end
      step();
      checks++; if (ins !== 32'h13 || pres !== 32'h0 || valid !== 1'b1) begin errors++; $display("FAIL stream_0 got %h/%h/%b exp 13/0/1", ins, pres, valid); end
      checks++; if (mif.imem_addr !== 32'h8) begin errors++; $display("FAIL stream_addr got %h exp 8", mif.imem_addr); end
      step();
      checks++; if (ins !== 32'h17 || pres !== 32'h4) begin errors++; $display("FAIL stream_1 got %h/%h exp 17/4", ins, pres); end
      step();
      checks++; if (ins !== 32'h1B || pres !== 32'h8) begin errors++; $display("FAIL stream_2 got %h/%h exp 1b/8", ins, pres); end
   endtask

   task automatic test_hazard();
      do_reset(1'b0, 1'b1);
      step(); step();
      hz = 1'b1;
      step();
      checks++; if (ins !== 32'h17 || pres !== 32'h4 || valid !== 1'b1) begin errors++; $display("FAIL hz_hold1 got %h/%h/%b exp 17/4/1", ins, pres, valid); end
      checks++; if (mif.imem_req !== 1'b0) begin errors++; $display("FAIL hz_credit1 req got %b exp 0", mif.imem_req); end
      step();
      checks++; if (ins !== 32'h17 || pres !== 32'h4) begin errors++; $display("FAIL hz_hold2 got %h/%h exp 17/4", ins, pres); end
      checks++; if (mif.imem_req !== 1'b0) begin errors++; $display("FAIL hz_credit2 req got %b exp 0", mif.imem_req); end
      hz = 1'b0;
      step();
      checks++; if (ins !== 32'h1B || pres !== 32'h8) begin errors++; $display("FAIL hz_pop1 got %h/%h exp 1b/8", ins, pres); end
      checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h10) begin errors++; $display("FAIL hz_req got %b/%h exp 1/10", mif.imem_req, mif.imem_addr); end
      step();
      checks++; if (ins !== 32'h1F || pres !== 32'hC) begin errors++; $display("FAIL hz_pop2 got %h/%h exp 1f/c", ins, pres); end
   endtask

   task automatic test_branch();
      do_reset(1'b1, 1'b1);
      step();
      // Two requests granted, first response arriving now
      branch = 1'b1; branoff = 32'h40; #1;
      checks++; if (mif.imem_req !== 1'b0) begin errors++; $display("FAIL br_req got %b exp 0", mif.imem_req); end
      step();
      branch = 1'b0; #1;
      checks++; if (ins !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL br_bubble got %h/%b exp 0/0", ins, valid); end
      checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr got %b/%h exp 1/40", mif.imem_req, mif.imem_addr); end
      step();
      checks++; if (ins !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL br_drop got %h/%b exp 0/0", ins, valid); end
      step();
      checks++; if (ins !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL br_wait got %h/%b exp 0/0", ins, valid); end
      step();
      checks++; if (ins !== 32'h53 || pres !== 32'h40 || valid !== 1'b1) begin errors++; $display("FAIL br_target got %h/%h/%b exp 53/40/1", ins, pres, valid); end
      step();
      checks++; if (ins !== 32'h57 || pres !== 32'h44) begin errors++; $display("FAIL br_next got %h/%h exp 57/44", ins, pres); end
   endtask

   task automatic test_trap();
      do_reset(1'b0, 1'b1);
      step();
      trap = 1'b1; trap_vec = 32'h100; branch = 1'b1; branoff = 32'h40; #1;
      checks++; if (mif.imem_req !== 1'b0) begin errors++; $display("FAIL trap_req got %b exp 0", mif.imem_req); end
      step();
      trap = 1'b0; branch = 1'b0; #1;
      checks++; if (mif.imem_addr !== 32'h100 || ins !== 32'h0) begin errors++; $display("FAIL trap_addr got %h ins %h exp 100/0", mif.imem_addr, ins); end
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL trap_bubble valid got %b exp 0", valid); end
      step();
      checks++; if (ins !== 32'h113 || pres !== 32'h100) begin errors++; $display("FAIL trap_target got %h/%h exp 113/100", ins, pres); end
   endtask

   task automatic test_bubbles();
      do_reset(1'b0, 1'b0);
      step(); step();
      checks++; if (ins !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL bub_ins got %h/%b exp 0/0", ins, valid); end
      checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h0) begin errors++; $display("FAIL bub_req got %b/%h exp 1/0", mif.imem_req, mif.imem_addr); end
`ifdef FETCH_PERF_EN
      checks++; if (bubble_cnt !== 32'd3) begin errors++; $display("FAIL bub_cnt got %0d exp 3", bubble_cnt); end
`endif
      gnt_en = 1'b1;
      step(); step();
      checks++; if (ins !== 32'h13 || pres !== 32'h0 || valid !== 1'b1) begin errors++; $display("FAIL bub_resume got %h/%h/%b exp 13/0/1", ins, pres, valid); end
`ifdef FETCH_PERF_EN
      checks++; if (fetch_cnt !== 32'd1 || bubble_cnt !== 32'd4) begin errors++; $display("FAIL bub_perf got %0d/%0d exp 1/4", fetch_cnt, bubble_cnt); end
`endif
   endtask

   task automatic test_dbg();
      // Continues from test_bubbles: ins=0x13, request 4 granted last cycle
      dbg = 1'b1; #1;
      checks++; if (mif.imem_req !== 1'b0) begin errors++; $display("FAIL dbg_req got %b exp 0", mif.imem_req); end
      step();
      checks++; if (ins !== 32'h13 || pres !== 32'h0) begin errors++; $display("FAIL dbg_hold got %h/%h exp 13/0", ins, pres); end
      dbg = 1'b0;
      step();
      checks++; if (ins !== 32'h17 || pres !== 32'h4) begin errors++; $display("FAIL dbg_release got %h/%h exp 17/4", ins, pres); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_hazard();
      test_branch();
      test_trap();
      test_bubbles();
      test_dbg();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
